doe_sbox_engine: RTL and testbench
==================================

// Module: doe_sbox_engine
// PURPOSE
//   Multi-cycle, time-multiplexed AES SubBytes/InvSubBytes engine for the DOE datapath.
//   Substitutes a WORD_BYTES-byte word using LANES parallel S-box lookups per cycle.
//   Selects the forward or inverse S-box per request.
//   Sits between the DOE key-expansion/round logic and its state registers.
//   Uses a valid/ready request/response handshake.
// PARAMETERS
//   WORD_BYTES  16  bytes per request word; data width = 8*WORD_BYTES
//   LANES       4   S-box lookups per cycle; WORD_BYTES % LANES == 0, LANES >= 1
//   INV_EN      1   1: inverse S-box instantiated; 0: req_inv ignored, forward only
// PORTS
//   clk        in   1              clock
//   reset_n    in   1              asynchronous active-low reset
//   zeroize    in   1              synchronous clear/abort, highest priority
//   req_valid  in   1              request present
//   req_ready  out  1              engine can accept request
//   req_inv    in   1              1 = InvSubBytes, 0 = SubBytes (sampled on accept)
//   req_data   in   8*WORD_BYTES   input word; byte i = req_data[8*i +: 8]
//   rsp_valid  out  1              result available
//   rsp_ready  in   1              consumer accepts result
//   rsp_data   out  8*WORD_BYTES   substituted word, byte i in same position as input
//   busy       out  1              state != IDLE
// BEHAVIOUR
//   - NGROUPS = WORD_BYTES/LANES; group g = bytes g*LANES .. g*LANES+LANES-1; group 0 first.
//   - FSM: IDLE -> SUB -> DONE -> IDLE. Registers: state, data_q, inv_q, grp_cnt.
//   - IDLE:
//     - req_ready = 1.
//     - On req_valid&&req_ready: data_q<=req_data, inv_q<=req_inv&INV_EN, grp_cnt<=0, ->SUB.
//   - SUB:
//     - Each cycle, replace group grp_cnt bytes of data_q in place with S(byte), or S^-1(byte) if inv_q.
//     - grp_cnt increments; after group NGROUPS-1 -> DONE, grp_cnt<=0.
//     - Other groups hold.
//   - DONE:
//     - rsp_valid = 1, rsp_data = data_q, both held stable until rsp_ready.
//     - On rsp_ready -> IDLE.
//   - Latency: rsp_valid rises exactly NGROUPS clock edges after the accepting edge.
//     - Example: 4 edges for 16/4; 1 edge for LANES=WORD_BYTES.
//   - Throughput: one word per NGROUPS+2 cycles. No accept in DONE, even if rsp_ready is high the same cycle.
//   - req_ready/rsp_valid/busy are decoded from state only. No combinational path from req_valid or rsp_ready.
//   - Inputs outside IDLE are ignored. req_data/req_inv changes after acceptance do not affect the result.
//   - rsp_data = data_q in all states (data_q is 0 after reset/zeroize). Consumers qualify with rsp_valid only.
//   - Tables:
//     - Forward = FIPS-197 S-box (00->63, 53->ed, ff->16).
//     - Inverse = FIPS-197 InvS-box (63->00, 00->52, ed->53).
//     - INV_EN=0 removes the inverse tables.
//   - grp_cnt width = max(1,$clog2(NGROUPS)). Wraps to 0 only via the DONE transition, never by overflow.
//   - zeroize: same edge, state<=IDLE, data_q<=0, inv_q<=0, grp_cnt<=0.
//     - Overrides a simultaneous request accept or response handshake.
//     - req_ready is 0 while zeroize is high.
//   - Reset (reset_n low, async): state=IDLE, data_q=0, inv_q=0, grp_cnt=0.
//     - Outputs: req_ready=1, rsp_valid=0, rsp_data=0, busy=0.
//     - Reset mid-SUB/DONE discards the word; no response is produced.
//   - Illegal parameters (WORD_BYTES%LANES!=0, LANES<1): elaboration-time $error.
// TESTING
//   1. Defaults, forward, req_data all 0x00 -> rsp_data all 0x63; rsp_valid 4 edges after accept; busy high 5 cycles.
//   2. Inverse: req_inv=1, all bytes 0x63 -> all 0x00.
//      Mixed bytes {ed,00,..} -> {53,52,..} at matching byte positions.
//   3. Backpressure: rsp_ready low 10 cycles in DONE -> rsp_valid/rsp_data stable.
//      req_ready stays 0; new request is accepted only the cycle after the rsp handshake.
//   4. Zeroize at SUB group 2 with rsp_ready=1 -> next cycle IDLE, req_ready=1, rsp_data=0, no rsp_valid pulse.
//   5. Reset_n asserted in DONE -> rsp_valid falls asynchronously. Release -> req_ready=1, busy=0.
//   6. Params WORD_BYTES=4/LANES=4 and 16/1, INV_EN=0:
//      - Exhaustive 0x00..0xff vs the FIPS-197 table.
//      - Latency 1 and 16 edges respectively.
//      - req_inv=1 yields forward result.

Source files
------------

// File: rtl/doe_sbox_engine.sv
// AES SubBytes/InvSubBytes word engine: LANES lookups per cycle, result NGROUPS edges after accept.
// One word in flight; the result is held in DONE until rsp_ready, and no request is taken until IDLE.
module doe_sbox_engine #(
  parameter int WORD_BYTES = 16,
  parameter int LANES      = 4,
  parameter int INV_EN     = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    zeroize,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_inv,
  input  logic [8*WORD_BYTES-1:0] req_data,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [8*WORD_BYTES-1:0] rsp_data,
  output logic                    busy
);

  localparam int NGROUPS = (LANES >= 1) ? (WORD_BYTES / LANES) : 1;
  localparam int GW      = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
  localparam logic [GW-1:0] LAST_GRP = GW'(NGROUPS - 1);

  generate
    if (LANES < 1 || (WORD_BYTES % LANES) != 0) begin : g_bad_params
      $error("doe_sbox_engine: WORD_BYTES must be a non-zero multiple of LANES");
    end
  endgenerate

  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // The inverse table is derived from the forward one so the two can never disagree.
  function automatic logic [0:255][7:0] f_inv_table();
    logic [0:255][7:0] t;
    t = '0;
    for (int i = 0; i < 256; i++) t[SBOX[i]] = 8'(i);
    return t;
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_SUB, S_DONE} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [8*WORD_BYTES-1:0] r_data;
  logic                    r_inv;
  logic [GW-1:0]           r_grp;
  int                      w_base;
  logic [LANES-1:0][7:0]   w_in;
  logic [LANES-1:0][7:0]   w_fwd;
  logic [LANES-1:0][7:0]   w_inv;
  logic [8*WORD_BYTES-1:0] w_data_sub;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (zeroize) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (req_valid) w_state_nxt = S_SUB;
        S_SUB:   if (r_grp == LAST_GRP) w_state_nxt = S_DONE;
        S_DONE:  if (rsp_ready) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign req_ready = (r_state == S_IDLE) && !zeroize;
  assign rsp_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign rsp_data  = r_data;

  always_comb begin
    w_base = int'(r_grp) * LANES;
    w_in   = '0;
    for (int l = 0; l < LANES; l++) w_in[l] = r_data[(w_base + l)*8 +: 8];
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign w_fwd[l] = SBOX[w_in[l]];
    if (INV_EN != 0) begin : g_inv
      localparam logic [0:255][7:0] INV_SBOX = f_inv_table();
      assign w_inv[l] = INV_SBOX[w_in[l]];
    end else begin : g_no_inv
      assign w_inv[l] = w_fwd[l];
    end
  end

  always_comb begin
    w_data_sub = r_data;
    for (int l = 0; l < LANES; l++)
      w_data_sub[(w_base + l)*8 +: 8] = r_inv ? w_inv[l] : w_fwd[l];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data <= '0;
      r_inv  <= 1'b0;
      r_grp  <= '0;
    end else if (zeroize) begin
      r_data <= '0;
      r_inv  <= 1'b0;
      r_grp  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_data <= req_data;
            r_inv  <= req_inv && (INV_EN != 0);
            r_grp  <= '0;
          end
        end
        S_SUB: begin
          r_data <= w_data_sub;
          r_grp  <= (r_grp == LAST_GRP) ? '0 : r_grp + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_doe_sbox_engine.sv
// Bench for doe_sbox_engine: default 16/4 instance plus 4/4 and 16/1 forward-only instances,
// checked against an S-box computed from GF(2^8) inversion and the AES affine map.
module tb_doe_sbox_engine;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic         a_zeroize, a_req_valid, a_req_inv, a_rsp_ready;
  logic         a_req_ready, a_rsp_valid, a_busy;
  logic [127:0] a_req_data, a_rsp_data;
  logic         b_zeroize, b_req_valid, b_req_inv, b_rsp_ready;
  logic         b_req_ready, b_rsp_valid, b_busy;
  logic [31:0]  b_req_data, b_rsp_data;
  logic         c_zeroize, c_req_valid, c_req_inv, c_rsp_ready;
  logic         c_req_ready, c_rsp_valid, c_busy;
  logic [127:0] c_req_data, c_rsp_data;

  doe_sbox_engine u_a (
    .clk(clk), .reset_n(rst_n), .zeroize(a_zeroize), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_inv(a_req_inv), .req_data(a_req_data), .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
    .rsp_data(a_rsp_data), .busy(a_busy));

  doe_sbox_engine #(.WORD_BYTES(4), .LANES(4), .INV_EN(0)) u_b (
    .clk(clk), .reset_n(rst_n), .zeroize(b_zeroize), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_inv(b_req_inv), .req_data(b_req_data), .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_data(b_rsp_data), .busy(b_busy));

  doe_sbox_engine #(.WORD_BYTES(16), .LANES(1), .INV_EN(0)) u_c (
    .clk(clk), .reset_n(rst_n), .zeroize(c_zeroize), .req_valid(c_req_valid), .req_ready(c_req_ready),
    .req_inv(c_req_inv), .req_data(c_req_data), .rsp_valid(c_rsp_valid), .rsp_ready(c_rsp_ready),
    .rsp_data(c_rsp_data), .busy(c_busy));

  // Reference S-box built from the field arithmetic, not from a table.
  logic [7:0] fwd_t [256];
  logic [7:0] inv_t [256];

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int k);
    return (v << k) | (v >> (8 - k));
  endfunction

  task automatic init_tables();
    logic [7:0] r, x;
    for (int i = 0; i < 256; i++) begin
      x = 8'(i);
      r = 8'h01;
      for (int k = 0; k < 254; k++) r = gmul(r, x);
      fwd_t[i] = r ^ rotl(r, 1) ^ rotl(r, 2) ^ rotl(r, 3) ^ rotl(r, 4) ^ 8'h63;
    end
    for (int i = 0; i < 256; i++) inv_t[fwd_t[i]] = 8'(i);
  endtask

  function automatic logic [127:0] ref_word(input logic [127:0] d, input logic inv, input int nb);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < nb; i++) r[8*i +: 8] = inv ? inv_t[d[8*i +: 8]] : fwd_t[d[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic set_req(input int sel, input logic v, input logic [127:0] d, input logic inv);
    case (sel)
      0:       begin a_req_valid = v; a_req_data = d;       a_req_inv = inv; end
      1:       begin b_req_valid = v; b_req_data = d[31:0]; b_req_inv = inv; end
      default: begin c_req_valid = v; c_req_data = d;       c_req_inv = inv; end
    endcase
  endtask

  task automatic set_rsp(input int sel, input logic v);
    case (sel)
      0:       a_rsp_ready = v;
      1:       b_rsp_ready = v;
      default: c_rsp_ready = v;
    endcase
  endtask

  function automatic logic rv_of(input int sel);
    return (sel == 0) ? a_rsp_valid : (sel == 1) ? b_rsp_valid : c_rsp_valid;
  endfunction
  function automatic logic busy_of(input int sel);
    return (sel == 0) ? a_busy : (sel == 1) ? b_busy : c_busy;
  endfunction
  function automatic logic rr_of(input int sel);
    return (sel == 0) ? a_req_ready : (sel == 1) ? b_req_ready : c_req_ready;
  endfunction
  function automatic logic [127:0] rd_of(input int sel);
    return (sel == 0) ? a_rsp_data : (sel == 1) ? {96'd0, b_rsp_data} : c_rsp_data;
  endfunction

  // One request/response exchange, started on a falling edge; inputs are scrambled after accept.
  task automatic xact(input int sel, input logic [127:0] d, input logic inv, input int hold,
                      output logic [127:0] got, output int lat, output int busy_n, output bit stable);
    int n;
    bit seen;
    set_req(sel, 1'b1, d, inv);
    n = 0; seen = 0; busy_n = 0; stable = 1; got = '0; lat = -1;
    while (!seen && n < 64) begin
      @(negedge clk);
      n++;
      if (n == 1) set_req(sel, 1'b0, rnd128(), 1'($urandom));
      if (busy_of(sel)) busy_n++;
      if (rv_of(sel)) seen = 1;
    end
    if (seen) begin
      lat = n - 1;
      got = rd_of(sel);
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        if (busy_of(sel)) busy_n++;
        if (!rv_of(sel) || rd_of(sel) !== got || rr_of(sel)) stable = 0;
      end
      set_rsp(sel, 1'b1);
      @(negedge clk);
      set_rsp(sel, 1'b0);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({a_req_ready, a_rsp_valid, a_busy} !== 3'b100 || a_rsp_data !== '0) begin
      failures++;
      $display("FAIL reset_a got rdy/vld/busy=%b data=%h exp 100 data=0", {a_req_ready, a_rsp_valid, a_busy}, a_rsp_data);
    end
    checks++;
    if ({b_req_ready, b_rsp_valid, b_busy, c_req_ready, c_rsp_valid, c_busy} !== 6'b100100 ||
        b_rsp_data !== '0 || c_rsp_data !== '0) begin
      failures++;
      $display("FAIL reset_bc got %b exp 100100", {b_req_ready, b_rsp_valid, b_busy, c_req_ready, c_rsp_valid, c_busy});
    end
  endtask

  task automatic test_forward();
    logic [127:0] got;
    int lat, bn;
    bit st;
    xact(0, '0, 1'b0, 0, got, lat, bn, st);
    checks++;
    if (got !== {16{8'h63}}) begin failures++; $display("FAIL fwd_zero got=%h exp=%h", got, {16{8'h63}}); end
    checks++;
    if (got !== ref_word('0, 1'b0, 16)) begin failures++; $display("FAIL fwd_zero_model got=%h exp=%h", got, ref_word('0, 1'b0, 16)); end
    checks++;
    if (lat !== 4) begin failures++; $display("FAIL fwd_latency got=%0d exp=4", lat); end
    checks++;
    if (bn !== 5) begin failures++; $display("FAIL fwd_busy_cycles got=%0d exp=5", bn); end
  endtask

  task automatic test_inverse();
    logic [127:0] got, d, expv;
    int lat, bn, hold;
    bit st;
    logic inv;
    xact(0, {16{8'h63}}, 1'b1, 0, got, lat, bn, st);
    checks++;
    if (got !== '0) begin failures++; $display("FAIL inv_63 got=%h exp=0", got); end
    d = rnd128();
    d[15:0] = 16'h00ed;
    xact(0, d, 1'b1, 0, got, lat, bn, st);
    checks++;
    if (got[15:0] !== 16'h5253) begin failures++; $display("FAIL inv_mixed_lo got=%h exp=5253", got[15:0]); end
    checks++;
    if (got !== ref_word(d, 1'b1, 16)) begin failures++; $display("FAIL inv_mixed got=%h exp=%h", got, ref_word(d, 1'b1, 16)); end
    for (int i = 0; i < 12; i++) begin
      d = rnd128(); inv = 1'($urandom); hold = int'($urandom_range(0, 3));
      expv = ref_word(d, inv, 16);
      xact(0, d, inv, hold, got, lat, bn, st);
      checks++;
      if (got !== expv || lat !== 4 || bn !== 5 + hold) begin
        failures++;
        $display("FAIL rand_word%0d got=%h lat=%0d busy=%0d exp=%h lat=4 busy=%0d", i, got, lat, bn, expv, 5 + hold);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] d1, d2, got;
    int n;
    d1 = rnd128(); d2 = rnd128();
    set_req(0, 1'b1, d1, 1'b0);
    @(negedge clk);
    set_req(0, 1'b0, rnd128(), 1'b1);
    n = 0;
    while (!a_rsp_valid && n < 20) begin @(negedge clk); n++; end
    got = a_rsp_data;
    checks++;
    if (!a_rsp_valid || got !== ref_word(d1, 1'b0, 16)) begin
      failures++; $display("FAIL bp_result vld=%b got=%h exp=%h", a_rsp_valid, got, ref_word(d1, 1'b0, 16));
    end
    set_req(0, 1'b1, d2, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (a_rsp_valid !== 1'b1 || a_rsp_data !== got || a_req_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold%0d vld=%b rdy=%b data=%h exp vld=1 rdy=0 data=%h", i, a_rsp_valid, a_req_ready, a_rsp_data, got);
      end
    end
    a_rsp_ready = 1'b1;
    @(negedge clk);
    a_rsp_ready = 1'b0;
    checks++;
    if (a_busy !== 1'b0 || a_req_ready !== 1'b1) begin
      failures++; $display("FAIL bp_no_accept_in_done busy=%b rdy=%b exp busy=0 rdy=1", a_busy, a_req_ready);
    end
    @(negedge clk);
    set_req(0, 1'b0, rnd128(), 1'b0);
    checks++;
    if (a_busy !== 1'b1) begin failures++; $display("FAIL bp_accept_next busy=%b exp=1", a_busy); end
    n = 0;
    while (!a_rsp_valid && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (a_rsp_data !== ref_word(d2, 1'b0, 16)) begin
      failures++; $display("FAIL bp_second got=%h exp=%h", a_rsp_data, ref_word(d2, 1'b0, 16));
    end
    a_rsp_ready = 1'b1;
    @(negedge clk);
    a_rsp_ready = 1'b0;
  endtask

  task automatic test_zeroize();
    bit seen;
    a_zeroize = 1'b1;
    set_req(0, 1'b1, rnd128(), 1'b0);
    #1;
    checks++;
    if (a_req_ready !== 1'b0) begin failures++; $display("FAIL zero_idle_ready got=%b exp=0", a_req_ready); end
    @(negedge clk);
    a_zeroize = 1'b0;
    set_req(0, 1'b0, '0, 1'b0);
    checks++;
    if (a_busy !== 1'b0 || a_rsp_data !== '0) begin
      failures++; $display("FAIL zero_idle busy=%b data=%h exp busy=0 data=0", a_busy, a_rsp_data);
    end
    set_req(0, 1'b1, rnd128() | 128'h1, 1'b0);
    @(negedge clk);
    set_req(0, 1'b0, '0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    a_zeroize = 1'b1;
    a_rsp_ready = 1'b1;
    @(negedge clk);
    a_zeroize = 1'b0;
    #1;
    checks++;
    if (a_busy !== 1'b0 || a_req_ready !== 1'b1 || a_rsp_data !== '0 || a_rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL zero_sub busy=%b rdy=%b vld=%b data=%h exp 0 1 0 0", a_busy, a_req_ready, a_rsp_valid, a_rsp_data);
    end
    seen = 0;
    for (int i = 0; i < 8; i++) begin @(negedge clk); if (a_rsp_valid) seen = 1; end
    a_rsp_ready = 1'b0;
    checks++;
    if (seen) begin failures++; $display("FAIL zero_no_pulse got rsp_valid=1 exp=0"); end
  endtask

  task automatic test_reset_async();
    logic [127:0] d, got;
    int n, lat, bn;
    bit st;
    set_req(0, 1'b1, rnd128(), 1'b0);
    @(negedge clk);
    set_req(0, 1'b0, '0, 1'b0);
    n = 0;
    while (!a_rsp_valid && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (a_rsp_valid !== 1'b1) begin failures++; $display("FAIL rst_reach_done vld=%b exp=1", a_rsp_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (a_rsp_valid !== 1'b0 || a_busy !== 1'b0 || a_rsp_data !== '0 || a_req_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_async vld=%b busy=%b rdy=%b data=%h exp 0 0 1 0", a_rsp_valid, a_busy, a_req_ready, a_rsp_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (a_req_ready !== 1'b1 || a_busy !== 1'b0) begin
      failures++; $display("FAIL rst_release rdy=%b busy=%b exp 1 0", a_req_ready, a_busy);
    end
    @(negedge clk);
    d = rnd128();
    xact(0, d, 1'b0, 0, got, lat, bn, st);
    checks++;
    if (got !== ref_word(d, 1'b0, 16) || lat !== 4) begin
      failures++; $display("FAIL rst_after got=%h lat=%0d exp=%h lat=4", got, lat, ref_word(d, 1'b0, 16));
    end
  endtask

  task automatic test_params();
    logic [127:0] d, got, expv;
    int lat, bn, rot;
    bit st;
    for (int w = 0; w < 64; w++) begin
      d = '0; rot = int'($urandom_range(0, 3));
      for (int k = 0; k < 4; k++) d[8*k +: 8] = 8'(4*w + ((k + rot) % 4));
      expv = ref_word(d, 1'b0, 4);
      xact(1, d, 1'($urandom), int'($urandom_range(0, 2)), got, lat, bn, st);
      checks++;
      if (got !== expv || lat !== 1 || !st) begin
        failures++; $display("FAIL p4x4_w%0d got=%h lat=%0d stable=%0d exp=%h lat=1", w, got[31:0], lat, st, expv[31:0]);
      end
    end
    for (int w = 0; w < 16; w++) begin
      d = '0;
      for (int k = 0; k < 16; k++) d[8*k +: 8] = 8'(16*w + k);
      expv = ref_word(d, 1'b0, 16);
      xact(2, d, 1'b1, 0, got, lat, bn, st);
      checks++;
      if (got !== expv || lat !== 16) begin
        failures++; $display("FAIL p16x1_w%0d got=%h lat=%0d exp=%h lat=16", w, got, lat, expv);
      end
    end
  endtask

  initial begin
    init_tables();
    rst_n = 1'b0;
    {a_zeroize, a_req_valid, a_req_inv, a_rsp_ready} = '0; a_req_data = '0;
    {b_zeroize, b_req_valid, b_req_inv, b_rsp_ready} = '0; b_req_data = '0;
    {c_zeroize, c_req_valid, c_req_inv, c_rsp_ready} = '0; c_req_data = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_forward();
    test_inverse();
    test_backpressure();
    test_zeroize();
    test_reset_async();
    test_params();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
